dds_sweep_ctrl: RTL

Phase-accumulator controller that sequences the tiny DDS sine LUT block. It holds a byte-programmable configuration: start/stop tuning words, step and dwell. It runs either a fixed-frequency tone or a linear frequency sweep (chirp) and presents a registered PHASE_W-bit phase word to the sine datapath every cycle.

---
 rtl/dds_pkg.sv | 34 +++
 rtl/dds_phase_acc.sv | 75 +++++++
 rtl/dds_sweep_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sweep controller: default widths, register
// map addresses, CTRL bit positions and the controller state encoding.
// Optional build macro used by the design: DDS_PHASE_OFFSET_EN
// (adds the POFS phase-offset register at address 7).
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int ACC_W_DEF   = 24;
    localparam int FTW_W_DEF   = 16;
    localparam int PHASE_W_DEF = 14;

    localparam logic [2:0] ADDR_START_L = 3'd0;
    localparam logic [2:0] ADDR_START_H = 3'd1;
    localparam logic [2:0] ADDR_STOP_L  = 3'd2;
    localparam logic [2:0] ADDR_STOP_H  = 3'd3;
    localparam logic [2:0] ADDR_STEP    = 3'd4;
    localparam logic [2:0] ADDR_DWELL   = 3'd5;
    localparam logic [2:0] ADDR_CTRL    = 3'd6;
    localparam logic [2:0] ADDR_POFS    = 3'd7;

    localparam int CTRL_MODE    = 0;
    localparam int CTRL_LOOP    = 1;
    localparam int CTRL_ACC_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIXED = 2'd1,
        ST_SWEEP = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
// Phase accumulator with synchronous clear and a registered phase output.
// Optional build macro: DDS_PHASE_OFFSET_EN adds a byte offset to the output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           zero the accumulator (wins over en)
//   en            advance acc by ftw this cycle
//   keep          controller stays active next cycle (gates phase_valid)
//   ftw           frequency tuning word, zero-extended into acc
//   pofs          phase offset byte (only with DDS_PHASE_OFFSET_EN)
//   phase_out     registered top PHASE_W bits of acc (plus offset)
//   phase_valid   phase_out carries an accumulated value
// -----------------------------------------------------------------------------
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int FTW_W   = FTW_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               keep,
    input  logic [FTW_W-1:0]   ftw,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [7:0]         pofs,
`endif
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid
);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               upd_q, upd_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
    logic               phase_valid_q, phase_valid_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-FTW_W){1'b0}}, ftw};
        end
        // upd marks that acc_q holds the result of an add, so the first valid
        // phase word already reflects one step of the tuning word.
        upd_d = en;
`ifdef DDS_PHASE_OFFSET_EN
        phase_out_d = acc_q[ACC_W-1 -: PHASE_W] + {pofs, {(PHASE_W-8){1'b0}}};
`else
        phase_out_d = acc_q[ACC_W-1 -: PHASE_W];
`endif
        phase_valid_d = upd_q && keep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            upd_q         <= 1'b0;
            phase_out_q   <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            upd_q         <= upd_d;
            phase_out_q   <= phase_out_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    assign phase_out   = phase_out_q;
    assign phase_valid = phase_valid_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Sequencer for the DDS sine LUT: byte-programmable config registers and a
// fixed-tone / linear-chirp FSM driving dds_phase_acc.
// Optional build macro: DDS_PHASE_OFFSET_EN (address 7 becomes POFS).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid/ready/addr/data    byte register writes, accepted only in IDLE
//   run                          level: 1 generate, 0 stop
//   phase_out, phase_valid       registered phase word to the sine LUT
//   busy                         FSM not in IDLE
//   sweep_done                   one-cycle pulse when the sweep reaches STOP
//
// state    | meaning
// IDLE     | stopped, config writes accepted, acc retained
// FIXED    | constant tone at START
// SWEEP    | ftw stepped by STEP every DWELL+1 cycles
// HOLD     | sweep finished without LOOP, tone held at STOP
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int FTW_W   = FTW_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic               run,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic               busy,
    output logic               sweep_done
);

    state_t           state_q, state_d;
    logic [FTW_W-1:0] start_q, start_d, stop_q, stop_d, ftw_q, ftw_d;
    logic [7:0]       step_q, step_d, dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
    logic             mode_q, mode_d, loop_q, loop_d;
    logic             at_stop_q, at_stop_d;
    logic             sweep_done_q, sweep_done_d;
    logic             acc_clr;
    logic             wr;
    logic [FTW_W:0]   nxt;
`ifdef DDS_PHASE_OFFSET_EN
    logic [7:0]       pofs_q, pofs_d;
`endif

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign wr        = cfg_valid && cfg_ready;

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        mode_d       = mode_q;
        loop_d       = loop_q;
        ftw_d        = ftw_q;
        dwell_cnt_d  = dwell_cnt_q;
        at_stop_d    = at_stop_q;
        sweep_done_d = 1'b0;
        acc_clr      = 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
        pofs_d       = pofs_q;
`endif
        nxt = {1'b0, ftw_q} + {{(FTW_W-7){1'b0}}, step_q};

        if (wr) begin
            case (cfg_addr)
                ADDR_START_L: start_d[7:0]  = cfg_data;
                ADDR_START_H: start_d[15:8] = cfg_data;
                ADDR_STOP_L:  stop_d[7:0]   = cfg_data;
                ADDR_STOP_H:  stop_d[15:8]  = cfg_data;
                ADDR_STEP:    step_d        = cfg_data;
                ADDR_DWELL:   dwell_d       = cfg_data;
                ADDR_CTRL: begin
                    mode_d  = cfg_data[CTRL_MODE];
                    loop_d  = cfg_data[CTRL_LOOP];
                    acc_clr = cfg_data[CTRL_ACC_CLR];
                end
                ADDR_POFS: begin
`ifdef DDS_PHASE_OFFSET_EN
                    pofs_d = cfg_data;
`endif
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d     = mode_q ? ST_SWEEP : ST_FIXED;
                    ftw_d       = start_q;
                    dwell_cnt_d = dwell_q;
                    at_stop_d   = 1'b0;
                end
            end
            ST_FIXED, ST_HOLD: begin
                if (!run) state_d = ST_IDLE;
            end
            ST_SWEEP: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (dwell_cnt_q == 8'd0) begin
                    dwell_cnt_d = dwell_q;
                    // In LOOP mode STOP is held for one full dwell period
                    // before the sweep restarts from START.
                    if (at_stop_q) begin
                        ftw_d     = start_q;
                        at_stop_d = 1'b0;
                    end else if (nxt >= {1'b0, stop_q}) begin
                        ftw_d        = stop_q;
                        sweep_done_d = 1'b1;
                        if (loop_q) at_stop_d = 1'b1;
                        else        state_d   = ST_HOLD;
                    end else begin
                        ftw_d = nxt[FTW_W-1:0];
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            mode_q       <= 1'b0;
            loop_q       <= 1'b0;
            ftw_q        <= '0;
            dwell_cnt_q  <= '0;
            at_stop_q    <= 1'b0;
            sweep_done_q <= 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
            pofs_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            mode_q       <= mode_d;
            loop_q       <= loop_d;
            ftw_q        <= ftw_d;
            dwell_cnt_q  <= dwell_cnt_d;
            at_stop_q    <= at_stop_d;
            sweep_done_q <= sweep_done_d;
`ifdef DDS_PHASE_OFFSET_EN
            pofs_q       <= pofs_d;
`endif
        end
    end

    assign sweep_done = sweep_done_q;

    dds_phase_acc #(
        .ACC_W   (ACC_W),
        .FTW_W   (FTW_W),
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr),
        .en          (state_q != ST_IDLE),
        .keep        (state_d != ST_IDLE),
        .ftw         (ftw_q),
`ifdef DDS_PHASE_OFFSET_EN
        .pofs        (pofs_q),
`endif
        .phase_out   (phase_out),
        .phase_valid (phase_valid)
    );

endmodule
